// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial-to-parallel receiver
package serial_pkg;

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_t;

  localparam int WORD_W = 8;

endpackage

// File: rtl/serial_to_parallel_8_bit_if.sv
// rtl/serial_to_parallel_8_bit_if.sv - serial input stream and parallel word handshake bundle
interface serial_to_parallel_8_bit_if
  import serial_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic             Sync;
  logic             Bit_Valid;
  logic             Bit_In;
  logic             Data_Ready;
  logic             Clear_Overrun;
  logic [WIDTH-1:0] Data_Out;
  logic             Data_Valid;
  logic             Busy;
  logic             Overrun;

  modport master (
    output Sync,
    output Bit_Valid,
    output Bit_In,
    output Data_Ready,
    output Clear_Overrun,
    input  Data_Out,
    input  Data_Valid,
    input  Busy,
    input  Overrun
  );

  modport slave (
    input  Sync,
    input  Bit_Valid,
    input  Bit_In,
    input  Data_Ready,
    input  Clear_Overrun,
    output Data_Out,
    output Data_Valid,
    output Busy,
    output Overrun
  );

endinterface

// File: rtl/serial_to_parallel_8_bit_word_holding_reg.sv
// rtl/serial_to_parallel_8_bit_word_holding_reg.sv - output word register with valid/ready and sticky overrun
module word_holding_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] Word,
  input  logic             Data_Ready,
  input  logic             Clear_Overrun,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Data_Valid,
  output logic             Overrun
);

  logic accept;
  logic drop;

  // A completing word may replace one being accepted on the same edge, so no bubble.
  assign accept = Data_Valid && Data_Ready;
  assign drop   = Load && Data_Valid && !Data_Ready;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
    end else if (Load && !drop) begin
      Data_Out   <= Word;
      Data_Valid <= 1'b1;
    end else if (accept) begin
      Data_Valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Overrun <= 1'b0;
    end else if (drop) begin
      Overrun <= 1'b1;
    end else if (Clear_Overrun) begin
      Overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel_8_bit.sv
// rtl/serial_to_parallel_8_bit.sv - LSB-first bit-serial receiver rebuilding parallel words
module serial_to_parallel_8_bit
  import serial_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                        CLK,
  input  logic                        Reset_n,
  serial_to_parallel_8_bit_if.slave   bus
);

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             load;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      count     <= count_nxt;
    end
  end

  // Sync behaves the same in both states: restart the frame, keeping a coincident bit as bit 0.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    count_nxt = count;
    load      = 1'b0;
    shifted   = {bus.Bit_In, shift_reg[WIDTH-1:1]};
    first_bit = {bus.Bit_In, {(WIDTH-1){1'b0}}};
    if (bus.Sync) begin
      state_nxt = RECV;
      shift_nxt = bus.Bit_Valid ? first_bit : '0;
      count_nxt = bus.Bit_Valid ? CNT_W'(1) : '0;
    end else if (state == RECV && bus.Bit_Valid) begin
      shift_nxt = shifted;
      if (count == CNT_W'(WIDTH - 1)) begin
        count_nxt = '0;
        load      = 1'b1;
      end else begin
        count_nxt = count + CNT_W'(1);
      end
    end
  end

  assign bus.Busy = (state == RECV) && (count != '0);

  word_holding_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .CLK           (CLK),
    .Reset_n       (Reset_n),
    .Load          (load),
    .Word          (shifted),
    .Data_Ready    (bus.Data_Ready),
    .Clear_Overrun (bus.Clear_Overrun),
    .Data_Out      (bus.Data_Out),
    .Data_Valid    (bus.Data_Valid),
    .Overrun       (bus.Overrun)
  );

endmodule

// File: tb/tb_serial_to_parallel_8_bit.sv
// tb/tb_serial_to_parallel_8_bit.sv - directed scoreboard bench for serial_to_parallel_8_bit
module tb_serial_to_parallel_8_bit;
  import serial_pkg::*;

  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  serial_to_parallel_8_bit_if #(.WIDTH(WORD_W)) bus ();

  serial_to_parallel_8_bit #(.WIDTH(WORD_W)) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic do_sync);
    for (int i = 0; i < 8; i++) begin
      bus.Sync      = do_sync && (i == 0);
      bus.Bit_Valid = 1'b1;
      bus.Bit_In    = w[i];
      step();
    end
    bus.Sync      = 1'b0;
    bus.Bit_Valid = 1'b0;
    bus.Bit_In    = 1'b0;
  endtask

  task automatic expect_word(input string tag);
    int n = 0;
    while (bus.Data_Valid !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    chk_bit({tag, "_valid"}, bus.Data_Valid, 1'b1);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=word", tag);
    end
    if (exp_q.size() > 0) chk({tag, "_data"}, bus.Data_Out, exp_q.pop_front());
  endtask

  initial begin
    logic [7:0] w;
    bus.Sync          = 1'b0;
    bus.Bit_Valid     = 1'b0;
    bus.Bit_In        = 1'b0;
    bus.Data_Ready    = 1'b0;
    bus.Clear_Overrun = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_data", bus.Data_Out, 8'h00);
    chk_bit("rst_valid", bus.Data_Valid, 1'b0);
    chk_bit("rst_busy", bus.Busy, 1'b0);
    chk_bit("rst_overrun", bus.Overrun, 1'b0);
    Reset_n = 1'b1;
    step();

    // A5 with ready held high: valid for exactly one cycle
    bus.Data_Ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1'b1);
    expect_word("a5");
    chk_bit("a5_busy", bus.Busy, 1'b0);
    step();
    chk_bit("a5_valid_drop", bus.Data_Valid, 1'b0);

    // bits before any Sync are ignored
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
    send_word(8'hFF, 1'b0);
    chk_bit("nosync_valid", bus.Data_Valid, 1'b0);
    chk_bit("nosync_busy", bus.Busy, 1'b0);
    exp_q.push_back(8'h01);
    send_word(8'h01, 1'b1);
    expect_word("w01");
    step();

    // partial word discarded by a second Sync
    bus.Sync = 1'b1;
    step();
    bus.Sync = 1'b0;
    w = 8'b0001_0110;
    for (int i = 0; i < 5; i++) begin
      bus.Bit_Valid = 1'b1;
      bus.Bit_In    = w[i];
      step();
    end
    bus.Bit_Valid = 1'b0;
    chk_bit("partial_busy", bus.Busy, 1'b1);
    bus.Sync = 1'b1;
    step();
    bus.Sync = 1'b0;
    chk_bit("resync_busy", bus.Busy, 1'b0);
    chk_bit("resync_valid", bus.Data_Valid, 1'b0);
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 1'b0);
    expect_word("w3c");
    chk_bit("w3c_overrun", bus.Overrun, 1'b0);
    step();
    chk_bit("w3c_valid_drop", bus.Data_Valid, 1'b0);

    // overrun: second word dropped while first is held
    bus.Data_Ready = 1'b0;
    exp_q.push_back(8'h12);
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b0);
    expect_word("w12");
    chk_bit("ovr_set", bus.Overrun, 1'b1);
    bus.Clear_Overrun = 1'b1;
    step();
    bus.Clear_Overrun = 1'b0;
    chk_bit("ovr_clear", bus.Overrun, 1'b0);
    chk_bit("ovr_hold_valid", bus.Data_Valid, 1'b1);
    chk("ovr_hold_data", bus.Data_Out, 8'h12);
    bus.Data_Ready = 1'b1;
    step();
    bus.Data_Ready = 1'b0;
    chk_bit("ovr_accept", bus.Data_Valid, 1'b0);

    // accept-and-complete on the same edge
    exp_q.push_back(8'h55);
    send_word(8'h55, 1'b0);
    expect_word("w55");
    w = 8'hAA;
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 8; i++) begin
      bus.Bit_Valid  = 1'b1;
      bus.Bit_In     = w[i];
      bus.Data_Ready = (i == 7);
      step();
    end
    bus.Bit_Valid  = 1'b0;
    bus.Data_Ready = 1'b0;
    chk_bit("swap_valid_now", bus.Data_Valid, 1'b1);
    expect_word("waa");
    chk_bit("swap_overrun", bus.Overrun, 1'b0);
    bus.Data_Ready = 1'b1;
    step();
    bus.Data_Ready = 1'b0;
    chk_bit("swap_accept", bus.Data_Valid, 1'b0);

    // asynchronous reset mid-word with a held word and overrun
    send_word(8'h5A, 1'b1);
    chk_bit("pre_rst_valid", bus.Data_Valid, 1'b1);
    send_word(8'h11, 1'b0);
    chk_bit("pre_rst_overrun", bus.Overrun, 1'b1);
    w = 8'h07;
    for (int i = 0; i < 3; i++) begin
      bus.Bit_Valid = 1'b1;
      bus.Bit_In    = w[i];
      step();
    end
    bus.Bit_Valid = 1'b0;
    chk_bit("pre_rst_busy", bus.Busy, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_data", bus.Data_Out, 8'h00);
    chk_bit("arst_valid", bus.Data_Valid, 1'b0);
    chk_bit("arst_busy", bus.Busy, 1'b0);
    chk_bit("arst_overrun", bus.Overrun, 1'b0);
    step();
    Reset_n = 1'b1;
    step();
    bus.Data_Ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_word(8'hC3, 1'b1);
    expect_word("wc3");
    chk_bit("wc3_overrun", bus.Overrun, 1'b0);
    step();
    chk_bit("wc3_valid_drop", bus.Data_Valid, 1'b0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_8_bit.md
Name: serial_to_parallel_8_bit

Overview:
Bit-serial receiver that rebuilds parallel words from an LSB-first serial stream, such as the Shift_Out stream of the multiplier's 8-bit shift registers.
Bits qualified by Bit_Valid are shifted in at the MSB. After WIDTH bits, the word transfers to an output holding register with a valid/ready handshake.
Frame alignment comes from a Sync pulse. Collection continues while a completed word waits for the consumer.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden.

Ports:
CLK  input  1  rising-edge clock.
Reset_n  input  1  asynchronous, active-low reset.
Sync  input  1  frame start; clears any partial word and enables collection.
Bit_Valid  input  1  Bit_In is valid this cycle.
Bit_In  input  1  serial data, LSB first.
Data_Ready  input  1  consumer accepts Data_Out when asserted together with Data_Valid.
Clear_Overrun  input  1  clears the sticky Overrun flag.
Data_Out  output  WIDTH  held word.
Data_Valid  output  1  Data_Out holds an unconsumed word.
Busy  output  1  a partial word is in progress (bit count is not 0 in RECV).
Overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (Reset_n=0, async): state=IDLE, shift reg=0, count=0, Data_Out=0, Data_Valid=0, Busy=0, Overrun=0.
- FSM IDLE: Bit_Valid is ignored.
  - Sync moves the FSM to RECV.
  - If Bit_Valid=1 in the same cycle as Sync, that bit is bit 0 of the frame (count=1).
- FSM RECV, on each Bit_Valid: shift reg <= {Bit_In, shift[WIDTH-1:1]}; count increments.
- Word complete: on the Bit_Valid with count=WIDTH-1, count wraps to 0 and the FSM stays in RECV (back-to-back words need no new Sync).
  - The completed word is {Bit_In, shift[WIDTH-1:1]}.
  - The completed word goes to Data_Out with Data_Valid=1 on the same clock edge. Latency: visible 1 cycle after the final bit is sampled.
- Sync in RECV: count=0 and shift reg=0; any partial word is discarded with no flag.
  - If Bit_Valid=1 in that cycle, it becomes the new bit 0.
  - Sync never affects Data_Out, Data_Valid or Overrun.
- Handshake: a transfer occurs when Data_Valid and Data_Ready are both 1 at a clock edge; Data_Valid then clears unless a new word completes in the same edge.
  - Data_Out is stable while Data_Valid=1 and not accepted.
  - Data_Ready while Data_Valid=0 has no effect.
- Completion when Data_Valid=0, or when Data_Valid=1 and Data_Ready=1: load the new word; Data_Valid=1. This is the simultaneous accept-and-complete case, and no bubble is allowed.
- Completion when Data_Valid=1 and Data_Ready=0: drop the new word, keep the old Data_Out, set Overrun=1.
- Overrun clears on Clear_Overrun. If Clear_Overrun and a new overrun occur in the same cycle, set wins.
- Busy = (state==RECV) && (count!=0), registered-state derived.
- Reset mid-word or mid-handshake: everything returns to reset values immediately; the word is lost.

Decomposition:
- Shared package serial_pkg:
  - rx_state_t enum {IDLE, RECV}
  - constant WORD_W=8
- Natural sub-module: word_holding_reg.
  - Holds Data_Out, Data_Valid and the Overrun logic.
  - Inputs: load strobe, word, Data_Ready, Clear_Overrun.
  - The top keeps the FSM, counter and shift register.

Test Plan:
- Reset, Sync, then 8 bits 1,0,1,0,0,1,0,1 with Data_Ready=1 -> Data_Out=8'hA5 and Data_Valid=1 for exactly 1 cycle, 1 cycle after the 8th bit; Busy=0 after.
- Bits sent before any Sync after reset -> no Data_Valid, count stays 0; Sync with Bit_Valid and Bit_In=1, then 7 zeros -> Data_Out=8'h01.
- Sync, 5 bits, Sync again, then the 8 bits of 8'h3C -> only 8'h3C is output, with no Overrun.
- Data_Ready=0; send 8'h12 then 8'h34 back-to-back -> Data_Out stays 8'h12 and Overrun=1; Clear_Overrun -> Overrun=0; Data_Ready=1 -> Data_Valid drops.
- 8'h55 held; Data_Ready=1 pulsed on the same edge that 8'hAA completes -> Data_Out=8'hAA, Data_Valid stays 1, Overrun=0.
- Reset_n asserted asynchronously mid-word (between clock edges) with Data_Valid=1 -> all outputs 0 immediately; Sync plus a full word afterwards is received correctly.
